regfile_mp: RTL

//  Parametrised multi-port register file for the pipelined CPU; successor of the single-write/two-read file.

---
 rtl/regfile_mp_if.sv | 31 +++
 rtl/regfile_mp.sv | 108 ++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle between the decode/issue/retire logic (master) and the multi-port register file (slave).
// There is no backpressure on this bundle. wenN and iss_en commit at the next rising clk edge.
// rdata, stall and pend are combinational results of the current inputs and stored state.
interface regfile_mp_if #(
  parameter int DSIZE = 16,
  parameter int ASIZE = 4,
  parameter int NRD   = 2
);
  logic                   wen0;
  logic [ASIZE-1:0]       waddr0;
  logic [DSIZE-1:0]       wdata0;
  logic                   wen1;
  logic [ASIZE-1:0]       waddr1;
  logic [DSIZE-1:0]       wdata1;
  logic [NRD*ASIZE-1:0]   raddr;
  logic [NRD*DSIZE-1:0]   rdata;
  logic                   iss_en;
  logic [ASIZE-1:0]       iss_addr;
  logic [NRD-1:0]         stall;
  logic [(2**ASIZE)-1:0]  pend;

  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, iss_en, iss_addr,
    input  rdata, stall, pend
  );

  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, iss_en, iss_addr,
    output rdata, stall, pend
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, same-cycle write->read forwarding,
// optional hardwired-zero R0 and a per-register pending scoreboard driving per-port stall flags.
module regfile_mp #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 4,
  parameter int NRD     = 2,
  parameter int ZERO_R0 = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int NREG = 2 ** ASIZE;

  logic [DSIZE-1:0]     regs_q [NREG];
  logic [DSIZE-1:0]     regs_d [NREG];
  logic [NREG-1:0]      pend_q;
  logic [NREG-1:0]      pend_d;
  logic                 wr0_ok;
  logic                 wr1_ok;
  logic                 iss_ok;
  logic [ASIZE-1:0]     rd_addr;
  logic [DSIZE-1:0]     rd_val;
  logic                 rd_stall;
  logic [NRD*DSIZE-1:0] rdata_c;
  logic [NRD-1:0]       stall_c;

  // Writes and issues aimed at a hardwired R0 are dropped before they reach state.
  always_comb begin
    wr0_ok = bus.wen0;
    wr1_ok = bus.wen1;
    iss_ok = bus.iss_en;
    if (ZERO_R0 != 0) begin
      if (bus.waddr0 == '0)   wr0_ok = 1'b0;
      if (bus.waddr1 == '0)   wr1_ok = 1'b0;
      if (bus.iss_addr == '0) iss_ok = 1'b0;
    end
  end

  // Port 1 is applied last so it wins a same-address collision.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr0_ok) regs_d[bus.waddr0] = bus.wdata0;
    if (wr1_ok) regs_d[bus.waddr1] = bus.wdata1;
  end

  // Issue outranks a same-cycle write: the new producer is still outstanding.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (iss_ok && (bus.iss_addr == ASIZE'(i))) begin
        pend_d[i] = 1'b1;
      end else if ((wr0_ok && (bus.waddr0 == ASIZE'(i))) ||
                   (wr1_ok && (bus.waddr1 == ASIZE'(i)))) begin
        pend_d[i] = 1'b0;
      end
    end
    if (ZERO_R0 != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  // Read ports: a write landing this cycle both forwards its data and clears the hazard.
  always_comb begin
    rdata_c  = '0;
    stall_c  = '0;
    rd_addr  = '0;
    rd_val   = '0;
    rd_stall = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr  = bus.raddr[k*ASIZE +: ASIZE];
      rd_val   = regs_q[rd_addr];
      rd_stall = pend_q[rd_addr];
      if (bus.wen0 && (bus.waddr0 == rd_addr)) begin
        rd_val   = bus.wdata0;
        rd_stall = 1'b0;
      end
      if (bus.wen1 && (bus.waddr1 == rd_addr)) begin
        rd_val   = bus.wdata1;
        rd_stall = 1'b0;
      end
      if ((ZERO_R0 != 0) && (rd_addr == '0)) begin
        rd_val   = '0;
        rd_stall = 1'b0;
      end
      rdata_c[k*DSIZE +: DSIZE] = rd_val;
      stall_c[k]                = rd_stall;
    end
  end

  assign bus.rdata = rdata_c;
  assign bus.stall = stall_c;
  assign bus.pend  = pend_q;
endmodule
